decoder_scan_n: RTL and testbench
=================================

Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; next generation of the team's 3-to-8 decoder.
- Operates in one of two modes:
  - Direct decode: a selector value is decoded to a one-hot output.
  - Auto-scan: the active output walks through all lines, with a programmable dwell time per line.
- Sits between control logic and multiplexed loads: display digit enables, bank selects, row strobes.

Parameters:
- SEL_W, 3, selector width in bits.
- OUT_W, 8, number of output lines; legal range 2..2**SEL_W.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low blanks the outputs.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- load  in  1  single-cycle strobe: capture sel (and dwell in scan mode).
- sel  in  SEL_W  index to decode, or scan start index.
- dwell  in  DWELL_W  extra cycles each line is held in scan mode.
- out  out  OUT_W  registered one-hot output.
- idx  out  SEL_W  index currently driven.
- wrap  out  1  one-cycle pulse when the scan wraps from OUT_W-1 to 0.
- err  out  1  sticky flag: sel >= OUT_W was loaded; cleared by the next legal load.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, idx=0, wrap=0, err=0, dwell register=0, dwell counter=0, state=IDLE.
- All outputs are registered. Latency from a load edge to the updated out/idx is exactly 1 clock.
- States:
  - IDLE: out=0. On en=1 & load=1, go to DEC if mode=0, or SCAN if mode=1.
  - DEC:
    - out=one-hot(idx), held indefinitely.
    - A new load with mode=0 updates idx.
    - A load with mode=1 enters SCAN.
  - SCAN:
    - Dwell counter counts 0..dwell_reg. At terminal count, idx increments and the counter clears.
    - Each line is therefore held dwell_reg+1 cycles; dwell=0 advances every cycle.
    - A load with mode=0 returns to DEC.
- en=0 in any state: next edge out=0, wrap=0, state=IDLE. idx and err are retained.
- Load capture:
  - sel is captured into idx; in SCAN, dwell is also captured into dwell_reg and the counter restarts at 0.
  - mode is sampled only when load=1. Changing mode without load has no effect.
- Illegal sel (sel >= OUT_W, possible only when OUT_W < 2**SEL_W): out=0, idx=sel, err=1.
  - In SCAN, the next advance goes to idx 0 and no wrap pulse is produced.
- Wrap-around: idx=OUT_W-1 at terminal count gives idx=0 and wrap=1 for exactly one cycle.
- Load coinciding with terminal count: load wins. idx=sel, counter=0, no wrap.
- Load with en=0 is ignored.
- Exactly one bit of out is set in DEC/SCAN with a legal idx; out=0 otherwise. Never more than one bit is set.

Optional Feature:
- Macro: DECODER_SCAN_ACTIVE_LOW_EN.
- Defined: out is driven inverted (one-cold; reset and blank value all ones), for common-anode loads. idx, wrap and err are unchanged.
- Undefined: active-high one-hot as above.

Decomposition:
- Package decoder_scan_pkg: state typedef (IDLE, DEC, SCAN) and a one-hot encode function parameterised by OUT_W.
- Sub-module dwell_timer: loadable DWELL_W-bit counter with a terminal-count output and synchronous clear.

Test Plan:
- Reset and decode (defaults): assert rst_n=0 mid-run, then release; en=1, mode=0, load with sel=5 -> out=8'h00 during reset; out=8'h20, idx=5 one clock after load.
- Scan wrap (defaults): en=1, mode=1, sel=6, dwell=2 -> idx 6,6,6,7,7,7,0 (wrap=1 on the cycle idx becomes 0), then 1..; out follows one-hot(idx).
- Load beats terminal count: in SCAN, load sel=2 on idx's terminal-count cycle -> next cycle idx=2, counter=0, wrap=0.
- Illegal selector (OUT_W=6, SEL_W=3): load sel=7 in DEC -> out=0, err=1; load sel=3 -> out=6'b001000, err=0.
- Enable drop: en=0 during SCAN at idx=4 -> next cycle out=0, state IDLE; en=1 + load mode=0 sel=4 -> out=8'h10.
- Active-low build (DECODER_SCAN_ACTIVE_LOW_EN defined): reset -> out=8'hFF; sel=0 decode -> out=8'hFE.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared state type and one-hot encoder for decoder_scan_n
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Widest decoder the encoder supports (SEL_W up to 8).
    localparam int MAX_OUT = 256;

    // One-hot of line i among n lines; an index at or beyond n yields all zeros.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [7:0] i, input logic [8:0] n);
        logic [MAX_OUT-1:0] oh;
        oh = '0;
        if ({1'b0, i} < n) begin
            oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable dwell counter with terminal count and synchronous clear
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clr,
    input  logic               run,
    input  logic [DWELL_W-1:0] limit_in,
    output logic               tc
);

    logic [DWELL_W-1:0] limit;
    logic [DWELL_W-1:0] cnt;

    assign tc = (cnt == limit);

    // load also restarts the count so a fresh line gets its full dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit <= '0;
            cnt   <= '0;
        end else if (load) begin
            limit <= limit_in;
            cnt   <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2^N decoder with auto-scan; DECODER_SCAN_ACTIVE_LOW_EN selects one-cold out
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap,
    output logic               err
);

    localparam logic [SEL_W:0]   OUT_W_X = (SEL_W+1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W-1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] POL = '1;
`else
    localparam logic [OUT_W-1:0] POL = '0;
`endif

    state_t             state, state_n;
    logic [SEL_W-1:0]   idx_n;
    logic [OUT_W-1:0]   out_n;
    logic               wrap_n, err_n;
    logic               t_load, t_clr, t_run, tc;
    logic               sel_bad, idx_bad;

    assign sel_bad = ({1'b0, sel} >= OUT_W_X);
    assign idx_bad = ({1'b0, idx} >= OUT_W_X);

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .clr      (t_clr),
        .run      (t_run),
        .limit_in (dwell),
        .tc       (tc)
    );

    // A load outranks a terminal count; disable outranks everything.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wrap_n  = 1'b0;
        err_n   = err;
        t_load  = 1'b0;
        t_run   = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else if (load) begin
            state_n = mode ? SCAN : DEC;
            idx_n   = sel;
            err_n   = sel_bad;
            t_load  = mode;
        end else if (state == SCAN) begin
            t_run = 1'b1;
            if (tc) begin
                if (idx == LAST) begin
                    idx_n  = '0;
                    wrap_n = 1'b1;
                end else if (idx_bad) begin
                    idx_n = '0;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end
        t_clr = (state_n != SCAN);
        out_n = POL;
        if (state_n != IDLE) begin
            out_n = POL ^ OUT_W'(onehot(8'(idx_n), 9'(OUT_W)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            out   <= POL;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            out   <= out_n;
            wrap  <= wrap_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - directed bench for decoder_scan_n (8-line and 6-line instances) against a line-hold model
module tb_decoder_scan_n;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] out8;
    logic [5:0] out6;
    logic [2:0] idx8, idx6;
    logic       wrap8, wrap6, err8, err6;

    int errors = 0;
    int checks = 0;
    bit live   = 1'b0;

    always #5 clk = ~clk;

    decoder_scan_n dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .dwell(dwell), .out(out8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    decoder_scan_n #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel(sel), .dwell(dwell), .out(out6), .idx(idx6), .wrap(wrap6), .err(err6)
    );

    // Model: whether a line is lit, which one, how long it has been held,
    // and how long it must be held before moving on.
    int W[2]       = '{8, 6};
    bit m_on[2]    = '{0, 0};
    bit m_scan[2]  = '{0, 0};
    int m_idx[2]   = '{0, 0};
    int m_dwell[2] = '{0, 0};
    int m_age[2]   = '{0, 0};
    bit m_err[2]   = '{0, 0};
    bit m_wrap[2]  = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_on[k] <= 0; m_scan[k] <= 0; m_idx[k] <= 0; m_dwell[k] <= 0;
                m_age[k] <= 0; m_err[k] <= 0; m_wrap[k] <= 0;
            end else if (!en) begin
                m_on[k] <= 0; m_wrap[k] <= 0;
            end else if (load) begin
                m_on[k] <= 1; m_scan[k] <= mode; m_idx[k] <= int'(sel); m_age[k] <= 0;
                if (mode) m_dwell[k] <= int'(dwell);
                m_err[k] <= (int'(sel) >= W[k]); m_wrap[k] <= 0;
            end else if (m_on[k] && m_scan[k]) begin
                if (m_age[k] + 1 > m_dwell[k]) begin
                    m_age[k]  <= 0;
                    m_wrap[k] <= (m_idx[k] == W[k] - 1);
                    m_idx[k]  <= (m_idx[k] >= W[k] - 1) ? 0 : m_idx[k] + 1;
                end else begin
                    m_age[k]  <= m_age[k] + 1;
                    m_wrap[k] <= 0;
                end
            end else begin
                m_wrap[k] <= 0;
            end
        end
    end

    function automatic int pol(input int v, input int w);
        return AL ? (v ^ ((1 << w) - 1)) : v;
    endfunction

    function automatic int exp_out(input int k);
        int v;
        v = (m_on[k] && m_idx[k] < W[k]) ? (1 << m_idx[k]) : 0;
        return pol(v, W[k]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_out8",  int'(out8),  exp_out(0));
            chk("cyc_idx8",  int'(idx8),  m_idx[0]);
            chk("cyc_wrap8", int'(wrap8), int'(m_wrap[0]));
            chk("cyc_err8",  int'(err8),  int'(m_err[0]));
            chk("cyc_out6",  int'(out6),  exp_out(1));
            chk("cyc_idx6",  int'(idx6),  m_idx[1]);
            chk("cyc_wrap6", int'(wrap6), int'(m_wrap[1]));
            chk("cyc_err6",  int'(err6),  int'(m_err[1]));
        end
    end

    task automatic step(input bit e, input bit m, input bit l, input int s, input int d);
        en = e; mode = m; load = l; sel = s[2:0]; dwell = d[7:0];
        @(posedge clk);
        #2;
    endtask

    int scan_idx[10] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_out8", int'(out8), pol(0, 8));
        chk("rst_out6", int'(out6), pol(0, 6));
        chk("rst_idx8", int'(idx8), 0);
        chk("rst_err8", int'(err8), 0);
        rst_n = 1'b1;
        live  = 1'b1;

        step(1, 0, 0, 0, 0);
        chk("idle_blank", int'(out8), pol(0, 8));
        step(1, 0, 1, 5, 0);
        chk("dec5_out8", int'(out8), pol(8'h20, 8));
        chk("dec5_idx8", int'(idx8), 5);
        chk("dec5_out6", int'(out6), pol(6'b100000, 6));
        step(1, 1, 0, 0, 0);
        chk("mode_no_load", int'(out8), pol(8'h20, 8));

        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out8", int'(out8), pol(0, 8));
        chk("async_rst_idx8", int'(idx8), 0);
        step(1, 0, 1, 5, 0);
        chk("load_in_rst", int'(out8), pol(0, 8));
        rst_n = 1'b1;
        step(1, 0, 1, 5, 0);
        chk("dec5_again", int'(out8), pol(8'h20, 8));

        step(1, 1, 1, 6, 2);
        chk("scan_err6", int'(err6), 1);
        chk("scan_out6_bad", int'(out6), pol(0, 6));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step(1, 1, 0, 0, 0);
            chk("scan_idx8",  int'(idx8),  scan_idx[i]);
            chk("scan_wrap8", int'(wrap8), (i == 6) ? 1 : 0);
            chk("scan_out8",  int'(out8),  pol(1 << scan_idx[i], 8));
            if (i == 3) begin
                chk("bad_adv_idx6",  int'(idx6),  0);
                chk("bad_adv_wrap6", int'(wrap6), 0);
                chk("bad_adv_err6",  int'(err6),  1);
            end
        end

        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 2, 2);
        chk("ldtc_idx8",  int'(idx8),  2);
        chk("ldtc_wrap8", int'(wrap8), 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("ldtc_hold", int'(idx8), 2);
        step(1, 1, 0, 0, 0);
        chk("ldtc_adv", int'(idx8), 3);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("scan_at4", int'(idx8), 4);

        step(0, 1, 0, 0, 0);
        chk("endrop_out8", int'(out8), pol(0, 8));
        chk("endrop_idx8", int'(idx8), 4);
        step(1, 1, 0, 0, 0);
        chk("reen_no_load", int'(out8), pol(0, 8));
        step(1, 0, 1, 4, 0);
        chk("reen_out8", int'(out8), pol(8'h10, 8));
        chk("reen_out6", int'(out6), pol(6'b010000, 6));

        step(1, 0, 1, 7, 0);
        chk("bad7_out6", int'(out6), pol(0, 6));
        chk("bad7_err6", int'(err6), 1);
        chk("bad7_idx6", int'(idx6), 7);
        chk("ok7_out8",  int'(out8), pol(8'h80, 8));
        step(1, 0, 0, 0, 0);
        chk("bad7_sticky", int'(err6), 1);
        step(1, 0, 1, 3, 0);
        chk("ok3_out6", int'(out6), pol(6'b001000, 6));
        chk("ok3_err6", int'(err6), 0);

        step(0, 0, 1, 1, 0);
        chk("load_en0_idx8", int'(idx8), 3);
        chk("load_en0_out8", int'(out8), pol(0, 8));
        step(1, 0, 1, 0, 0);
        chk("dec0_out8", int'(out8), pol(8'h01, 8));

        step(1, 1, 1, 6, 0);
        chk("d0_idx8_a", int'(idx8), 6);
        step(1, 1, 0, 0, 0);
        chk("d0_idx8_b", int'(idx8), 7);
        step(1, 1, 0, 0, 0);
        chk("d0_idx8_c", int'(idx8), 0);
        chk("d0_wrap8",  int'(wrap8), 1);
        step(1, 1, 0, 0, 0);
        chk("d0_idx8_d", int'(idx8), 1);
        chk("d0_wrap8_off", int'(wrap8), 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);

        live = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
